// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, writeback-source codes, immediate
// formats and the ID/EX payload layout.
package decode_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_PC4 = 2'd2;

   // IMM_NONE covers R-type, which carries no immediate
   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic [RAW-1:0]  rs1;
      logic [RAW-1:0]  rs2;
      logic [RAW-1:0]  rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            alu_src;
      logic            branch;
      logic            jump;
      logic [1:0]      result_src;
      logic [3:0]      alu_op;
   } idex_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator, sign-extended from instr[31] to DATA_W.
// Zero latency, no flow control.
module imm_gen
   import decode_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]       instr,
   input  imm_type_t         imm_type,
   output logic [DATA_W-1:0] imm
);

   logic signed [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // signed source, so widening sign-extends
   assign imm = DATA_W'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode with ID/EX register: 1-cycle latency, stalls IF/ID on load-use (and on WB
// read-after-write unless ID_BYPASS_EN enables the write-through bypass); EX flush wins.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_d,
   input  logic [DATA_W-1:0] pc_d,
   input  logic              valid_d,
   output logic [REG_AW-1:0] A1,
   output logic [REG_AW-1:0] A2,
   input  logic [DATA_W-1:0] RD1,
   input  logic [DATA_W-1:0] RD2,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] A3W,
   input  logic [DATA_W-1:0] WD3W,
   input  logic              flush_e,
   output logic              stall_fd,
   output logic              valid_e,
   output logic [DATA_W-1:0] pc_e,
   output logic [DATA_W-1:0] rs1_val_e,
   output logic [DATA_W-1:0] rs2_val_e,
   output logic [DATA_W-1:0] imm_e,
   output logic [REG_AW-1:0] rs1_e,
   output logic [REG_AW-1:0] rs2_e,
   output logic [REG_AW-1:0] rd_e,
   output logic              reg_write_e,
   output logic              mem_read_e,
   output logic              mem_write_e,
   output logic              alu_src_e,
   output logic              branch_e,
   output logic              jump_e,
   output logic [1:0]        result_src_e,
   output logic [3:0]        alu_op_e
);

`ifdef ID_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic              f7b5;
   logic [REG_AW-1:0] rd_a;
   logic [REG_AW-1:0] rs1_u;
   logic [REG_AW-1:0] rs2_u;
   logic              use1;
   logic              use2;
   imm_type_t         imm_type;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] rs1_val;
   logic [DATA_W-1:0] rs2_val;
   idex_t             ctrl;
   idex_t             d;
   idex_t             q;
   logic              hz_lu;
   logic              hz_wb;

   assign opcode = instr_d[6:0];
   assign funct3 = instr_d[14:12];
   assign f7b5   = instr_d[30];
   assign rd_a   = REG_AW'(instr_d[11:7]);
   assign A1     = REG_AW'(instr_d[19:15]);
   assign A2     = REG_AW'(instr_d[24:20]);

   imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
      .instr    (instr_d),
      .imm_type (imm_type),
      .imm      (imm)
   );

   // alu_src means operand B is the immediate: every immediate format except BRANCH
   always_comb begin
      ctrl     = '0;
      imm_type = IMM_NONE;
      use1     = 1'b0;
      use2     = 1'b0;
      case (opcode)
         OPC_OP: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = {f7b5, funct3};
            use1           = 1'b1;
            use2           = 1'b1;
         end
         OPC_OPIMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = {(funct3 == 3'b101) & f7b5, funct3};
            imm_type       = IMM_I;
            use1           = 1'b1;
         end
         OPC_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
            imm_type        = IMM_I;
            use1            = 1'b1;
         end
         OPC_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm_type       = IMM_S;
            use1           = 1'b1;
            use2           = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = {1'b0, funct3};
            imm_type    = IMM_B;
            use1        = 1'b1;
            use2        = 1'b1;
         end
         OPC_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_PC4;
            imm_type        = IMM_J;
         end
         OPC_JALR: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_PC4;
            imm_type        = IMM_I;
            use1            = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm_type       = IMM_U;
         end
         default: ;
      endcase
   end

   // unused source fields read as x0 so EX forwarding never matches them
   assign rs1_u = use1 ? A1 : '0;
   assign rs2_u = use2 ? A2 : '0;

   always_comb begin
      rs1_val = RD1;
      rs2_val = RD2;
      if (BYPASS && RegWriteW && (A3W == rs1_u)) rs1_val = WD3W;
      if (BYPASS && RegWriteW && (A3W == rs2_u)) rs2_val = WD3W;
      if (rs1_u == '0) rs1_val = '0;
      if (rs2_u == '0) rs2_val = '0;
   end

   always_comb begin
      d = '0;
      if (valid_d) begin
         d         = ctrl;
         d.valid   = 1'b1;
         d.pc      = pc_d;
         d.imm     = imm;
         d.rs1     = rs1_u;
         d.rs2     = rs2_u;
         d.rs1_val = rs1_val;
         d.rs2_val = rs2_val;
         d.rd      = ctrl.reg_write ? rd_a : '0;
      end
   end

   assign hz_lu = valid_d && valid_e && mem_read_e && (rd_e != '0) &&
                  ((use1 && (rd_e == A1)) || (use2 && (rd_e == A2)));

   assign hz_wb = !BYPASS && valid_d && RegWriteW && (A3W != '0) &&
                  ((use1 && (A3W == A1)) || (use2 && (A3W == A2)));

   assign stall_fd = (hz_lu || hz_wb) && !flush_e;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  q <= '0;
      else if (flush_e || stall_fd) q <= '0;
      else                         q <= d;
   end

   assign valid_e      = q.valid;
   assign pc_e         = q.pc;
   assign rs1_val_e    = q.rs1_val;
   assign rs2_val_e    = q.rs2_val;
   assign imm_e        = q.imm;
   assign rs1_e        = q.rs1;
   assign rs2_e        = q.rs2;
   assign rd_e         = q.rd;
   assign reg_write_e  = q.reg_write;
   assign mem_read_e   = q.mem_read;
   assign mem_write_e  = q.mem_write;
   assign alu_src_e    = q.alu_src;
   assign branch_e     = q.branch;
   assign jump_e       = q.jump;
   assign result_src_e = q.result_src;
   assign alu_op_e     = q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage against an instruction-level reference model.
module tb_decode_stage;

`ifdef ID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr_d, pc_d;
   logic        valid_d;
   logic [4:0]  A1, A2, A3W;
   logic [31:0] RD1, RD2, WD3W;
   logic        RegWriteW, flush_e, stall_fd;
   logic        valid_e, reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e;
   logic [31:0] pc_e, rs1_val_e, rs2_val_e, imm_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic [1:0]  result_src_e;
   logic [3:0]  alu_op_e;

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
      .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .RegWriteW(RegWriteW), .A3W(A3W), .WD3W(WD3W),
      .flush_e(flush_e), .stall_fd(stall_fd), .valid_e(valid_e), .pc_e(pc_e),
      .rs1_val_e(rs1_val_e), .rs2_val_e(rs2_val_e), .imm_e(imm_e), .rs1_e(rs1_e),
      .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
      .mem_write_e(mem_write_e), .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e),
      .result_src_e(result_src_e), .alu_op_e(alu_op_e)
   );

   typedef struct {
      logic        v;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mr, mw, as, br, jp;
      logic [1:0]  rsrc;
      logic [3:0]  op;
   } ex_t;

   int   n_vec = 0;
   int   n_err = 0;
   ex_t  m;
   logic seen_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ex_t ex_zero();
      ex_t e;
      e = '{default: '0};
      return e;
   endfunction

   function automatic logic [6:0] opc();
      return instr_d[6:0];
   endfunction

   // source usage straight from the ISA format table
   function automatic bit uses1();
      return !(opc() inside {7'h37, 7'h17, 7'h6F});
   endfunction

   function automatic bit uses2();
      return opc() inside {7'h33, 7'h23, 7'h63};
   endfunction

   function automatic logic [31:0] ref_imm();
      logic [31:0] i;
      int          v;
      i = instr_d;
      v = 0;
      case (opc())
         7'h13, 7'h03, 7'h67: v = (i[31] ? -2048 : 0) + int'(i[30:20]);
         7'h23: v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
         7'h63: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
         7'h37, 7'h17: v = int'(i & 32'hFFFFF000);
         7'h6F: v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rd_data);
      if (r == 0) return 0;
      if (BYP && RegWriteW && A3W == r) return WD3W;
      return rd_data;
   endfunction

   function automatic ex_t ref_decode();
      ex_t         e;
      logic [6:0]  o;
      e = ex_zero();
      o = opc();
      if (!valid_d) return e;
      e.v    = 1'b1;
      e.pc   = pc_d;
      e.rw   = o inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17};
      e.mr   = (o == 7'h03);
      e.mw   = (o == 7'h23);
      e.br   = (o == 7'h63);
      e.jp   = (o == 7'h6F) || (o == 7'h67);
      e.as   = o inside {7'h13, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h37, 7'h17};
      e.rsrc = e.mr ? 2'd1 : (e.jp ? 2'd2 : 2'd0);
      if (o == 7'h33)                               e.op = {instr_d[30], instr_d[14:12]};
      else if (o == 7'h13 && instr_d[14:12] == 3'd5) e.op = {instr_d[30], instr_d[14:12]};
      else if (o == 7'h13 || o == 7'h63)            e.op = {1'b0, instr_d[14:12]};
      e.imm  = ref_imm();
      e.rs1  = uses1() ? instr_d[19:15] : 5'd0;
      e.rs2  = uses2() ? instr_d[24:20] : 5'd0;
      e.a    = operand(e.rs1, RD1);
      e.b    = operand(e.rs2, RD2);
      e.rd   = e.rw ? instr_d[11:7] : 5'd0;
      return e;
   endfunction

   function automatic bit ref_stall();
      bit lu, wb;
      lu = valid_d && m.v && m.mr && m.rd != 0 &&
           ((uses1() && m.rd == instr_d[19:15]) || (uses2() && m.rd == instr_d[24:20]));
      wb = !BYP && valid_d && RegWriteW && A3W != 0 &&
           ((uses1() && A3W == instr_d[19:15]) || (uses2() && A3W == instr_d[24:20]));
      return (lu || wb) && !flush_e;
   endfunction

   task automatic chk_ex();
      chk("valid_e", valid_e, m.v);         chk("pc_e", pc_e, m.pc);
      chk("rs1_val_e", rs1_val_e, m.a);     chk("rs2_val_e", rs2_val_e, m.b);
      chk("imm_e", imm_e, m.imm);           chk("rs1_e", rs1_e, m.rs1);
      chk("rs2_e", rs2_e, m.rs2);           chk("rd_e", rd_e, m.rd);
      chk("reg_write_e", reg_write_e, m.rw); chk("mem_read_e", mem_read_e, m.mr);
      chk("mem_write_e", mem_write_e, m.mw); chk("alu_src_e", alu_src_e, m.as);
      chk("branch_e", branch_e, m.br);      chk("jump_e", jump_e, m.jp);
      chk("result_src_e", result_src_e, m.rsrc); chk("alu_op_e", alu_op_e, m.op);
   endtask

   // inputs already driven; checks combinational outputs, clocks once, checks ID/EX
   task automatic cycle();
      ex_t nxt;
      bit  es;
      #1;
      es = ref_stall();
      seen_stall = stall_fd;
      chk("stall_fd", stall_fd, es);
      chk("A1", A1, instr_d[19:15]);
      chk("A2", A2, instr_d[24:20]);
      nxt = (flush_e || es) ? ex_zero() : ref_decode();
      @(posedge clk);
      #1;
      m = nxt;
      chk_ex();
   endtask

   task automatic drive(input logic [31:0] ins, input logic v);
      instr_d = ins;
      valid_d = v;
      pc_d    = pc_d + 4;
      RD1     = $urandom;
      RD2     = $urandom;
   endtask

   logic [6:0]  ops [9];
   logic [31:0] ri;

   initial begin
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      rst_n = 1'b0; instr_d = 0; pc_d = 32'h1000; valid_d = 0;
      RD1 = 0; RD2 = 0; RegWriteW = 0; A3W = 0; WD3W = 0; flush_e = 0;
      m = ex_zero();
      #12;
      chk_ex();
      chk("rst_stall", stall_fd, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // addi x5,x0,7
      drive(32'h00700293, 1'b1);
      cycle();
      chk("addi_valid", valid_e, 1'b1);  chk("addi_rd", rd_e, 5);
      chk("addi_imm", imm_e, 7);         chk("addi_rw", reg_write_e, 1'b1);
      chk("addi_alusrc", alu_src_e, 1'b1); chk("addi_rs1val", rs1_val_e, 0);

      // asynchronous reset with a live EX entry
      #2; rst_n = 1'b0; #1;
      m = ex_zero();
      chk("arst_valid", valid_e, 1'b0);
      chk_ex();
      chk("arst_stall", stall_fd, 1'b0);
      valid_d = 1'b0;
      #1; rst_n = 1'b1;
      cycle();

      // lw x6,0(x5) ; add x7,x6,x6
      drive(32'h0002A303, 1'b1);
      cycle();
      drive(32'h006303B3, 1'b1);
      cycle();
      chk("lu_stall", seen_stall, 1'b1);
      chk("lu_bubble", valid_e, 1'b0);
      cycle();
      chk("lu_release", seen_stall, 1'b0);
      chk("lu_add_valid", valid_e, 1'b1);
      chk("lu_add_rs1", rs1_e, 6);
      chk("lu_add_rs2", rs2_e, 6);

      // addi x6,x5,1 while WB writes x5
      drive(32'h00128313, 1'b1);
      RD1 = 32'h1; RegWriteW = 1'b1; A3W = 5'd5; WD3W = 32'hDEADBEEF;
      cycle();
`ifdef ID_BYPASS_EN
      chk("byp_stall", seen_stall, 1'b0);
      chk("byp_val", rs1_val_e, 32'hDEADBEEF);
`else
      chk("wb_stall", seen_stall, 1'b1);
      chk("wb_bubble", valid_e, 1'b0);
      RegWriteW = 1'b0; RD1 = 32'hDEADBEEF;
      cycle();
      chk("wb_release", seen_stall, 1'b0);
      chk("wb_val", rs1_val_e, 32'hDEADBEEF);
`endif
      RegWriteW = 1'b0;

      // flush coincident with a load-use hazard
      drive(32'h0002A303, 1'b1);
      cycle();
      drive(32'h006303B3, 1'b1);
      flush_e = 1'b1;
      cycle();
      chk("fl_stall", seen_stall, 1'b0);
      chk("fl_bubble", valid_e, 1'b0);
      flush_e = 1'b0;

      // beq x0,x0,-4
      drive(32'hFE000EE3, 1'b1);
      cycle();
      chk("beq_imm", imm_e, 32'hFFFFFFFC); chk("beq_branch", branch_e, 1'b1);
      chk("beq_rw", reg_write_e, 1'b0);    chk("beq_rd", rd_e, 0);

      // randomized stream; front end holds IF/ID while stalled
      for (int n = 0; n < 400; n++) begin
         if (!seen_stall) begin
            ri = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 8)];
            ri[11:7]  = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            drive(ri, $urandom_range(0, 99) < 85);
         end else begin
            RD1 = $urandom;
            RD2 = $urandom;
         end
         RegWriteW = ($urandom_range(0, 99) < 40);
         A3W       = 5'($urandom_range(0, 3));
         WD3W      = $urandom;
         flush_e   = ($urandom_range(0, 99) < 10);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
